// File: rtl/active_pixel_ctrl_if.sv
// Pixel-controller bus bundle: loader stream, ping-pong write port, read port and line timing.
// No logic of its own; the slave modport is the controller side, master the driver/memory side.
// Backpressure is carried by s_ready_o only.
interface active_pixel_ctrl_if #(
    parameter int ADDR_W = 11
);
    logic [ADDR_W-1:0] last_idx_i;
    logic              s_valid_i;
    logic              s_data_i;
    logic              s_ready_o;
    logic              wen_o;
    logic [ADDR_W-1:0] waddr_o;
    logic              wdata_o;
    logic              mem_selector_o;
    logic              line_start_i;
    logic              pixel_en_i;
    logic [ADDR_W-1:0] raddr_o;
    logic              rd_active_o;
    logic              pix_valid_o;
    logic              swap_o;

    modport slave (
        input  last_idx_i, s_valid_i, s_data_i, line_start_i, pixel_en_i,
        output s_ready_o, wen_o, waddr_o, wdata_o, mem_selector_o,
               raddr_o, rd_active_o, pix_valid_o, swap_o
    );

    modport master (
        output last_idx_i, s_valid_i, s_data_i, line_start_i, pixel_en_i,
        input  s_ready_o, wen_o, waddr_o, wdata_o, mem_selector_o,
               raddr_o, rd_active_o, pix_valid_o, swap_o
    );
endinterface

// File: rtl/active_pixel_ctrl.sv
// Active-pixel line controller: loads one line of bits into a ping-pong memory and scans the other bank.
// Latency: write strobe and read address registered (1 cycle); pix_valid_o follows its address by 1 cycle.
// Backpressure: s_ready_o drops once a bank is full and rises again only after the bank swap.
module active_pixel_ctrl #(
    parameter int ADDR_W = 11
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    active_pixel_ctrl_if.slave   bus
);

    typedef enum logic {W_LOAD, W_FULL} wstate_t;
    typedef enum logic {R_IDLE, R_RUN}  rstate_t;

    wstate_t           wstate;
    logic [ADDR_W-1:0] wcnt;
    logic              wen_q;
    logic [ADDR_W-1:0] waddr_q;
    logic              wdata_q;
    logic              sel_q;
    logic              sel_d_q;
    logic              swap_q;

    rstate_t           rstate;
    logic [ADDR_W-1:0] raddr_q;
    logic [ADDR_W-1:0] last_q;
    logic              pix_valid_q;

    logic              handshake;

    assign handshake = bus.s_valid_i && (wstate == W_LOAD);

    // Writer: fills the write bank, then waits for a line start to flip banks.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wstate  <= W_LOAD;
            wcnt    <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= 1'b0;
            sel_q   <= 1'b0;
            sel_d_q <= 1'b0;
            swap_q  <= 1'b0;
        end else begin
            wen_q   <= 1'b0;
            sel_d_q <= sel_q;
            // Pulse lands the cycle after the selector has already changed.
            swap_q  <= sel_q ^ sel_d_q;
            case (wstate)
                W_LOAD: begin
                    if (handshake) begin
                        wen_q   <= 1'b1;
                        waddr_q <= wcnt;
                        wdata_q <= bus.s_data_i;
                        if (wcnt == bus.last_idx_i) begin
                            wstate <= W_FULL;
                            wcnt   <= '0;
                        end else begin
                            wcnt <= wcnt + ADDR_W'(1);
                        end
                    end
                end
                W_FULL: begin
                    if (bus.line_start_i) begin
                        sel_q  <= ~sel_q;
                        wstate <= W_LOAD;
                        wcnt   <= '0;
                    end
                end
                default: wstate <= W_LOAD;
            endcase
        end
    end

    // Reader: line start always restarts the scan, even mid-line.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rstate      <= R_IDLE;
            raddr_q     <= '0;
            last_q      <= '0;
            pix_valid_q <= 1'b0;
        end else begin
            pix_valid_q <= (rstate == R_RUN) && bus.pixel_en_i && !bus.line_start_i;
            if (bus.line_start_i) begin
                rstate  <= R_RUN;
                raddr_q <= '0;
                last_q  <= bus.last_idx_i;
            end else if ((rstate == R_RUN) && bus.pixel_en_i) begin
                if (raddr_q == last_q) begin
                    rstate <= R_IDLE;
                end else begin
                    raddr_q <= raddr_q + ADDR_W'(1);
                end
            end
        end
    end

    assign bus.s_ready_o      = (wstate == W_LOAD);
    assign bus.wen_o          = wen_q;
    assign bus.waddr_o        = waddr_q;
    assign bus.wdata_o        = wdata_q;
    assign bus.mem_selector_o = sel_q;
    assign bus.swap_o         = swap_q;
    assign bus.raddr_o        = raddr_q;
    assign bus.rd_active_o    = (rstate == R_RUN);
    assign bus.pix_valid_o    = pix_valid_q;

endmodule

// File: tb/tb_active_pixel_ctrl.sv
// Bench for active_pixel_ctrl: directed vector table, hand-written corner sequences,
// then randomized traffic against a count-based reference model.
module tb_active_pixel_ctrl;
    localparam int AW = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    active_pixel_ctrl_if #(.ADDR_W(AW)) bus ();
    active_pixel_ctrl #(.ADDR_W(AW)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        bit sv, d, ls, pe;
        bit wen; int waddr; bit wdata, ready, sel, swap;
        int raddr; bit act, pix;
    } vec_t;
    vec_t tbl[11];

    // Reference model: counts bits accepted into the write bank and the scan position.
    int m_last, m_loaded, m_pos, m_rlast;
    bit m_bank, m_run, m_toggled;
    bit e_wen, e_wdata, e_ready, e_sel, e_swap, e_pix, e_act;
    int e_waddr, e_raddr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_reset(input int last);
        m_last = last; m_loaded = 0; m_pos = 0; m_rlast = 0;
        m_bank = 0; m_run = 0; m_toggled = 0;
        e_wen = 0; e_waddr = 0; e_wdata = 0; e_ready = 1; e_sel = 0;
        e_swap = 0; e_pix = 0; e_act = 0; e_raddr = 0;
    endtask

    task automatic model_step(input bit sv, input bit d, input bit ls, input bit pe);
        bit full, hs, tog;
        full = (m_loaded > m_last);
        hs   = sv && !full;
        tog  = 0;
        e_wen = hs;
        if (hs) begin
            e_waddr = m_loaded; e_wdata = d; m_loaded++;
        end else if (full && ls) begin
            m_bank = !m_bank; m_loaded = 0; tog = 1;
        end
        e_swap = m_toggled; m_toggled = tog;
        e_sel = m_bank;
        e_ready = (m_loaded <= m_last);
        e_pix = m_run && pe && !ls;
        if (ls) begin
            m_pos = 0; m_run = 1; m_rlast = m_last;
        end else if (m_run && pe) begin
            if (m_pos == m_rlast) m_run = 0;
            else m_pos++;
        end
        e_raddr = m_pos; e_act = m_run;
    endtask

    task automatic compare_model(input string tag);
        chk({tag, ".wen"},   32'(bus.wen_o),          32'(e_wen));
        if (e_wen) begin
            chk({tag, ".waddr"}, 32'(bus.waddr_o),    32'(e_waddr));
            chk({tag, ".wdata"}, 32'(bus.wdata_o),    32'(e_wdata));
        end
        chk({tag, ".ready"}, 32'(bus.s_ready_o),      32'(e_ready));
        chk({tag, ".sel"},   32'(bus.mem_selector_o), 32'(e_sel));
        chk({tag, ".swap"},  32'(bus.swap_o),         32'(e_swap));
        chk({tag, ".raddr"}, 32'(bus.raddr_o),        32'(e_raddr));
        chk({tag, ".act"},   32'(bus.rd_active_o),    32'(e_act));
        chk({tag, ".pix"},   32'(bus.pix_valid_o),    32'(e_pix));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".sel"},   32'(bus.mem_selector_o), 0);
        chk({tag, ".wen"},   32'(bus.wen_o),          0);
        chk({tag, ".waddr"}, 32'(bus.waddr_o),        0);
        chk({tag, ".wdata"}, 32'(bus.wdata_o),        0);
        chk({tag, ".raddr"}, 32'(bus.raddr_o),        0);
        chk({tag, ".act"},   32'(bus.rd_active_o),    0);
        chk({tag, ".pix"},   32'(bus.pix_valid_o),    0);
        chk({tag, ".swap"},  32'(bus.swap_o),         0);
        chk({tag, ".ready"}, 32'(bus.s_ready_o),      1);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic drive(input bit sv, input bit d, input bit ls, input bit pe);
        @(negedge clk);
        bus.s_valid_i    = sv;
        bus.s_data_i     = d;
        bus.line_start_i = ls;
        bus.pixel_en_i   = pe;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int last, input bit check);
        @(negedge clk);
        rst = 1'b1;
        bus.s_valid_i = 0; bus.s_data_i = 0; bus.line_start_i = 0; bus.pixel_en_i = 0;
        bus.last_idx_i = AW'(last);
        #1;
        if (check) check_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;
        model_reset(last);
    endtask

    initial begin
        //             sv d ls pe  wen waddr wdata rdy sel swp raddr act pix
        tbl[0]  = '{1, 1, 0, 0,  1, 0, 1, 1, 0, 0,  0, 0, 0};
        tbl[1]  = '{1, 0, 0, 0,  1, 1, 0, 1, 0, 0,  0, 0, 0};
        tbl[2]  = '{1, 1, 0, 0,  1, 2, 1, 1, 0, 0,  0, 0, 0};
        tbl[3]  = '{1, 1, 0, 0,  1, 3, 1, 0, 0, 0,  0, 0, 0};
        tbl[4]  = '{0, 0, 1, 0,  0, 3, 1, 1, 1, 0,  0, 1, 0};
        tbl[5]  = '{0, 0, 0, 0,  0, 3, 1, 1, 1, 1,  0, 1, 0};
        tbl[6]  = '{0, 0, 0, 1,  0, 3, 1, 1, 1, 0,  1, 1, 1};
        tbl[7]  = '{0, 0, 0, 1,  0, 3, 1, 1, 1, 0,  2, 1, 1};
        tbl[8]  = '{0, 0, 0, 1,  0, 3, 1, 1, 1, 0,  3, 1, 1};
        tbl[9]  = '{0, 0, 0, 1,  0, 3, 1, 1, 1, 0,  3, 0, 1};
        tbl[10] = '{0, 0, 0, 1,  0, 3, 1, 1, 1, 0,  3, 0, 0};

        bus.s_valid_i = 0; bus.s_data_i = 0; bus.line_start_i = 0; bus.pixel_en_i = 0;
        bus.last_idx_i = AW'(3);

        // Load four bits, swap, then scan the line.
        do_reset(3, 1);
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].sv, tbl[i].d, tbl[i].ls, tbl[i].pe);
            chk($sformatf("tbl%0d.wen", i),   32'(bus.wen_o),          32'(tbl[i].wen));
            chk($sformatf("tbl%0d.waddr", i), 32'(bus.waddr_o),        32'(tbl[i].waddr));
            chk($sformatf("tbl%0d.wdata", i), 32'(bus.wdata_o),        32'(tbl[i].wdata));
            chk($sformatf("tbl%0d.ready", i), 32'(bus.s_ready_o),      32'(tbl[i].ready));
            chk($sformatf("tbl%0d.sel", i),   32'(bus.mem_selector_o), 32'(tbl[i].sel));
            chk($sformatf("tbl%0d.swap", i),  32'(bus.swap_o),         32'(tbl[i].swap));
            chk($sformatf("tbl%0d.raddr", i), 32'(bus.raddr_o),        32'(tbl[i].raddr));
            chk($sformatf("tbl%0d.act", i),   32'(bus.rd_active_o),    32'(tbl[i].act));
            chk($sformatf("tbl%0d.pix", i),   32'(bus.pix_valid_o),    32'(tbl[i].pix));
        end

        // Partial load then line start: no swap, loading resumes at address 2.
        do_reset(3, 0);
        drive(1, 1, 0, 0);
        drive(1, 0, 0, 0);
        drive(0, 0, 1, 0);
        chk("partial.sel", 32'(bus.mem_selector_o), 0);
        chk("partial.ready", 32'(bus.s_ready_o), 1);
        drive(0, 0, 0, 0);
        chk("partial.swap", 32'(bus.swap_o), 0);
        drive(1, 1, 0, 0);
        chk("partial.wen", 32'(bus.wen_o), 1);
        chk("partial.waddr", 32'(bus.waddr_o), 2);

        // Line start coincident with the final handshake defers the swap.
        do_reset(3, 0);
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        drive(1, 1, 1, 0);
        chk("coinc.waddr", 32'(bus.waddr_o), 3);
        chk("coinc.ready", 32'(bus.s_ready_o), 0);
        chk("coinc.sel", 32'(bus.mem_selector_o), 0);
        drive(0, 0, 0, 0);
        chk("coinc.noswap", 32'(bus.swap_o), 0);
        chk("coinc.sel_hold", 32'(bus.mem_selector_o), 0);
        drive(0, 0, 1, 0);
        chk("coinc.sel_flip", 32'(bus.mem_selector_o), 1);
        chk("coinc.reload_rdy", 32'(bus.s_ready_o), 1);
        drive(0, 0, 0, 0);
        chk("coinc.swap", 32'(bus.swap_o), 1);
        drive(0, 0, 0, 0);
        chk("coinc.swap_end", 32'(bus.swap_o), 0);

        // Asynchronous reset mid-load and mid-line, then a fresh load into bank0.
        do_reset(3, 0);
        drive(1, 1, 0, 0);
        drive(1, 1, 1, 0);
        drive(0, 0, 0, 1);
        chk("midrst.raddr_pre", 32'(bus.raddr_o), 1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        rst = 1'b0;
        drive(1, 1, 0, 0);
        chk("midrst.wen", 32'(bus.wen_o), 1);
        chk("midrst.waddr", 32'(bus.waddr_o), 0);
        chk("midrst.wdata", 32'(bus.wdata_o), 1);
        chk("midrst.sel", 32'(bus.mem_selector_o), 0);

        // Line restart while scanning.
        do_reset(3, 0);
        drive(0, 0, 1, 0);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);
        chk("restart.raddr_pre", 32'(bus.raddr_o), 2);
        drive(0, 0, 1, 1);
        chk("restart.raddr", 32'(bus.raddr_o), 0);
        chk("restart.pix", 32'(bus.pix_valid_o), 0);
        chk("restart.act", 32'(bus.rd_active_o), 1);

        // Full-width line: 2048 pixels and 2048 loaded bits, no wrap.
        do_reset(2047, 0);
        drive(0, 0, 1, 0);
        for (int i = 0; i < 2047; i++) drive(0, 0, 0, 1);
        chk("wide.raddr_last", 32'(bus.raddr_o), 2047);
        chk("wide.act_last", 32'(bus.rd_active_o), 1);
        drive(0, 0, 0, 1);
        chk("wide.act_end", 32'(bus.rd_active_o), 0);
        chk("wide.raddr_hold", 32'(bus.raddr_o), 2047);
        chk("wide.pix_last", 32'(bus.pix_valid_o), 1);
        drive(0, 0, 0, 1);
        chk("wide.raddr_nowrap", 32'(bus.raddr_o), 2047);
        chk("wide.pix_off", 32'(bus.pix_valid_o), 0);
        for (int i = 0; i < 2047; i++) drive(1, 1, 0, 0);
        chk("wide.ready_before", 32'(bus.s_ready_o), 1);
        drive(1, 0, 0, 0);
        chk("wide.waddr_last", 32'(bus.waddr_o), 2047);
        chk("wide.ready_full", 32'(bus.s_ready_o), 0);

        // Randomized traffic against the model, several line lengths.
        for (int seg = 0; seg < 6; seg++) begin
            int last;
            last = (seg == 0) ? 0 : int'($urandom_range(1, 7));
            do_reset(last, 0);
            for (int c = 0; c < 500; c++) begin
                bit sv, d, ls, pe;
                sv = ($urandom_range(0, 9) < 6);
                d  = 1'($urandom);
                ls = ($urandom_range(0, 19) == 0);
                pe = ($urandom_range(0, 9) < 7);
                model_step(sv, d, ls, pe);
                drive(sv, d, ls, pe);
                compare_model($sformatf("rnd%0d.%0d", seg, c));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/active_pixel_ctrl.md
ACTIVE_PIXEL_CTRL -- requirements
Module: active_pixel_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, pixel-memory address width; all address ports and last_idx_i are ADDR_W bits.
REQ-002 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port last_idx_i  input  ADDR_W  index of last pixel per line; must be stable while loading or reading.
REQ-005 SHALL have port s_valid_i  input  1  loader pixel-bit valid.
REQ-006 SHALL have port s_data_i  input  1  loader active-pixel bit.
REQ-007 SHALL have port s_ready_o  output  1  loader ready; high only in writer state W_LOAD, decoded from the state register.
REQ-008 SHALL have port wen_o / waddr_o / wdata_o  output  1 / ADDR_W / 1  registered write strobe, address and data to the ping-pong pixel memory.
REQ-009 SHALL have port mem_selector_o  output  1  bank select: 0 writes bank0 and reads bank1; 1 writes bank1 and reads bank0.
REQ-010 SHALL have port line_start_i  input  1  one-cycle line-start pulse.
REQ-011 SHALL have port pixel_en_i  input  1  pixel tick; advances the read pointer.
REQ-012 SHALL have port raddr_o  output  ADDR_W  registered read address to the pixel memory.
REQ-013 SHALL have port rd_active_o  output  1  reader in state R_RUN.
REQ-014 SHALL have port pix_valid_o  output  1  high the cycle the memory read data is valid (1-cycle read latency).
REQ-015 SHALL have port swap_o  output  1  one-cycle pulse on the cycle after mem_selector_o toggles.

Function
REQ-016 Writer FSM SHALL have two states, W_LOAD and W_FULL, with write counter wcnt.
REQ-017 In W_LOAD, a handshake (s_valid_i & s_ready_o) SHALL register wen_o=1, waddr_o=wcnt, wdata_o=s_data_i for the next cycle; wcnt SHALL then increment.
REQ-018 Without a handshake, wen_o SHALL be 0 the next cycle, and waddr_o/wdata_o SHALL hold.
REQ-019 A handshake with wcnt==last_idx_i SHALL move the writer to W_FULL and clear wcnt; s_ready_o SHALL be 0 from the next cycle.
REQ-020 The writer SHALL stay in W_FULL, accepting nothing, until a swap.
REQ-021 Swap: line_start_i while in W_FULL SHALL toggle mem_selector_o at that edge, return the writer to W_LOAD with wcnt=0, and pulse swap_o the following cycle.
REQ-022 line_start_i in W_LOAD SHALL NOT swap; the reader re-reads the current read bank.
REQ-023 If line_start_i coincides with the final handshake, the swap SHALL NOT occur that cycle; it SHALL occur at the next line_start_i.
REQ-024 Reader FSM SHALL have two states, R_IDLE and R_RUN.
REQ-025 line_start_i in any reader state SHALL set raddr_o=0, capture last_idx_i into last_q, and enter R_RUN; an in-progress line is abandoned.
REQ-026 In R_RUN, pixel_en_i SHALL increment raddr_o.
REQ-027 In R_RUN, pixel_en_i with raddr_o==last_q SHALL return the reader to R_IDLE, with raddr_o held at last_q.
REQ-028 pixel_en_i in R_IDLE, or on the same cycle as line_start_i, SHALL be ignored.
REQ-029 pix_valid_o SHALL equal (R_RUN & pixel_en_i & ~line_start_i), registered once.
REQ-030 Counters SHALL never wrap past last_idx_i or last_q; with last_idx_i = 2^ADDR_W-1, a line is 2048 pixels.

Reset
REQ-031 While rst_i is high, outputs SHALL be: mem_selector_o=0, wen_o=0, waddr_o=0, wdata_o=0, raddr_o=0, rd_active_o=0, pix_valid_o=0, swap_o=0, s_ready_o=1 (writer W_LOAD, wcnt=0; reader R_IDLE).
REQ-032 Reset mid-load or mid-line SHALL discard partial progress; the first load after reset targets bank0.

Verification
REQ-033 last_idx=3; four handshakes with bits 1,0,1,1 -> wen_o pulses at waddr 0..3 with data 1,0,1,1; s_ready_o=0 after the 4th; then line_start -> mem_selector_o=1, swap_o pulses 1 cycle later.
REQ-034 last_idx=3; line_start, then pixel_en held high -> raddr_o 0,1,2,3; pix_valid_o high 4 cycles, each 1 cycle after its address; rd_active_o drops after addr 3.
REQ-035 Partial load of 2 of 4 bits, then line_start -> no toggle, no swap_o; loading continues at waddr 2.
REQ-036 line_start on the same cycle as the 4th handshake -> no swap; next line_start -> swap.
REQ-037 rst_i asserted mid-load (wcnt=2) and mid-line (raddr=1) -> all outputs take REQ-031 values immediately; after release, a reload starts at waddr 0 in bank0.
REQ-038 line_start during R_RUN at raddr=2 -> raddr_o=0 next cycle, no pix_valid_o for that cycle.
